// File: rtl/alu_mem_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_mem_seq : register-mapped ALU slave with full-width multiply and a     |
// |               restoring iterative divider. ALU_DIVZERO_CNT_EN adds a       |
// |               divide-by-zero counter at address 8.                         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module alu_mem_seq #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      rd_wr,
   input  logic [ADDR_WIDTH-1:0]     addr,
   input  logic [DATA_WIDTH-1:0]     wr_data,
   output logic [DATA_WIDTH-1:0]     rd_data,
   output logic [2*DATA_WIDTH-1:0]   res_out,
   output logic                      busy,
   output logic                      done
);

   localparam int W  = DATA_WIDTH;
   localparam int RW = 2 * DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] EXEC   = 2'd1;
   localparam logic [1:0] DIV    = 2'd2;
   localparam logic [1:0] FINISH = 2'd3;

   logic [1:0]    state;
   logic [W-1:0]  reg_a;
   logic [W-1:0]  reg_b;
   logic [2:0]    reg_op;
   logic [2:0]    op_q;
   logic [RW-1:0] old_res;
   logic          err;
   logic [W-1:0]  divisor;
   logic [W-1:0]  quo;
   logic [W-1:0]  rem;
   logic [CW-1:0] div_cnt;

   logic          wr_en;
   logic          rd_en;
   logic          is_div;
   logic [W:0]    div_shift;
   logic [W:0]    div_diff;
   logic          div_ge;
   logic [RW-1:0] single_res;
   logic [W-1:0]  rd_next;

   assign wr_en  = enable & ~rd_wr;
   assign rd_en  = enable & rd_wr;
   assign busy   = (state != IDLE);
   assign is_div = (reg_op == 3'd4) || (reg_op == 3'd5);

   // One restoring step: bring down the next dividend bit, subtract if it fits.
   assign div_shift = {rem, quo[W-1]};
   assign div_diff  = div_shift - {1'b0, divisor};
   assign div_ge    = ~div_diff[W];

   always_comb begin
      single_res = '0;
      case (reg_op)
         3'd1:    single_res = RW'(reg_a) + RW'(reg_b);
         3'd2:    single_res = RW'(reg_a) - RW'(reg_b);
         3'd3:    single_res = RW'(reg_a) * RW'(reg_b);
         3'd6:    single_res = RW'(reg_a & reg_b);
         3'd7:    single_res = RW'(reg_a ^ reg_b);
         default: single_res = '0;
      endcase
   end

`ifdef ALU_DIVZERO_CNT_EN
   logic [7:0] dz_cnt;
   logic       dz_done;

   assign dz_done = (state == EXEC) && is_div && (reg_b == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         dz_cnt <= '0;
      end else if (wr_en && (addr == ADDR_WIDTH'(8))) begin
         dz_cnt <= '0;
      end else if (dz_done && (dz_cnt != 8'hFF)) begin
         dz_cnt <= dz_cnt + 8'd1;
      end
   end
`endif

   always_comb begin
      rd_next = '0;
      case (addr)
         ADDR_WIDTH'(0): rd_next = reg_a;
         ADDR_WIDTH'(1): rd_next = reg_b;
         ADDR_WIDTH'(2): rd_next = W'(reg_op);
         ADDR_WIDTH'(4): rd_next = W'({err, busy});
         ADDR_WIDTH'(5): rd_next = res_out[W-1:0];
         ADDR_WIDTH'(6): rd_next = res_out[RW-1:W];
         ADDR_WIDTH'(7): rd_next = old_res[W-1:0];
`ifdef ALU_DIVZERO_CNT_EN
         ADDR_WIDTH'(8): rd_next = W'(dz_cnt);
`endif
         default:        rd_next = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         reg_a   <= '0;
         reg_b   <= '0;
         reg_op  <= '0;
         op_q    <= '0;
         old_res <= '0;
         res_out <= '0;
         err     <= 1'b0;
         done    <= 1'b0;
         rd_data <= '0;
         divisor <= '0;
         quo     <= '0;
         rem     <= '0;
         div_cnt <= '0;
      end else begin
         done <= 1'b0;
         if (rd_en) begin
            rd_data <= rd_next;
         end
         if (wr_en && !busy) begin
            if (addr == ADDR_WIDTH'(0)) reg_a  <= wr_data;
            if (addr == ADDR_WIDTH'(1)) reg_b  <= wr_data;
            if (addr == ADDR_WIDTH'(2)) reg_op <= wr_data[2:0];
         end
         case (state)
            IDLE: begin
               if (wr_en && (addr == ADDR_WIDTH'(3)) && wr_data[0]) begin
                  state <= EXEC;
               end
            end
            EXEC: begin
               op_q <= reg_op;
               if (is_div && (reg_b != '0)) begin
                  divisor <= reg_b;
                  quo     <= reg_a;
                  rem     <= '0;
                  div_cnt <= CW'(W - 1);
                  state   <= DIV;
               end else begin
                  old_res <= res_out;
                  res_out <= is_div ? {RW{1'b1}} : single_res;
                  err     <= is_div;
                  done    <= 1'b1;
                  state   <= IDLE;
               end
            end
            DIV: begin
               rem <= div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
               quo <= {quo[W-2:0], div_ge};
               if (div_cnt == '0) begin
                  state <= FINISH;
               end else begin
                  div_cnt <= div_cnt - CW'(1);
               end
            end
            FINISH: begin
               old_res <= res_out;
               res_out <= (op_q == 3'd4) ? RW'(quo) : RW'(rem);
               err     <= 1'b0;
               done    <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_mem_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_mem_seq : directed and random checks of alu_mem_seq (8-bit build)   |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module tb_alu_mem_seq;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          rd_wr = 1'b0;
   logic [7:0]    addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [DW-1:0] rd_data;
   logic [15:0]   res_out;
   logic          busy;
   logic          done;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] m_res = '0;
   logic [15:0] m_old = '0;
   logic        m_err = 1'b0;
   int          m_dz = 0;

   alu_mem_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .rd_wr   (rd_wr),
      .addr    (addr),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .res_out (res_out),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model(input logic [2:0] op, input int a, input int b);
      case (op)
         3'd1:    return 16'(a + b);
         3'd2:    return 16'(a - b);
         3'd3:    return 16'(a * b);
         3'd4:    return (b == 0) ? 16'hFFFF : 16'(a / b);
         3'd5:    return (b == 0) ? 16'hFFFF : 16'(a % b);
         3'd6:    return 16'(a & b);
         3'd7:    return 16'(a ^ b);
         default: return 16'h0000;
      endcase
   endfunction

   task automatic bus_write(input int a, input int d);
      enable = 1'b1; rd_wr = 1'b0; addr = 8'(a); wr_data = DW'(d);
      @(posedge clk); #1;
      enable = 1'b0;
   endtask

   task automatic bus_read(input int a, output logic [DW-1:0] d);
      enable = 1'b1; rd_wr = 1'b1; addr = 8'(a);
      @(posedge clk); #1;
      enable = 1'b0;
      d = rd_data;
   endtask

   task automatic run_op(input int a, input int b, input logic [2:0] op, input bit poke);
      int lat;
      int busy_cnt;
      int exp_lat;
      bit is_div;
      logic [15:0] exp_res;
      logic [DW-1:0] d;
      is_div  = (op == 3'd4) || (op == 3'd5);
      exp_lat = (is_div && b != 0) ? DW + 2 : 1;
      exp_res = model(op, a, b);
      bus_write(0, a);
      bus_write(1, b);
      bus_write(2, op);
      bus_write(3, 1);
      busy_cnt = busy ? 1 : 0;
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         if (poke && n == 1) begin
            enable = 1'b1; rd_wr = 1'b0; addr = 8'd0; wr_data = 8'd9;
         end
         @(posedge clk); #1;
         enable = 1'b0;
         if (done) begin
            lat = n;
            break;
         end
         if (busy) busy_cnt++;
      end
      check("done_latency", lat, exp_lat);
      check("busy_cycles", busy_cnt, exp_lat);
      check("busy_at_done", busy, 0);
      check("res_out", res_out, exp_res);
      m_old = m_res;
      m_res = exp_res;
      m_err = is_div && (b == 0);
      if (m_err && m_dz < 255) m_dz++;
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      bus_read(7, d);
      check("old_lo", d, m_old[7:0]);
      bus_read(4, d);
      check("status", d, {6'd0, m_err, 1'b0});
   endtask

   initial begin
      logic [DW-1:0] d;
      int ra, rb;
      logic [2:0] rop;

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_rd_data", rd_data, 0);
      check("rst_res_out", res_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      bus_read(4, d);
      check("rst_status", d, 0);

      run_op(200, 100, 3'd1, 1'b0);
      check("add_res", res_out, 16'h012C);
      bus_read(6, d);
      check("add_res_hi", d, 8'h01);
      bus_read(5, d);
      check("add_res_lo", d, 8'h2C);

      run_op(255, 255, 3'd3, 1'b0);
      check("mul_res", res_out, 16'hFE01);
      run_op(3, 5, 3'd2, 1'b0);
      check("sub_res", res_out, 16'hFFFE);
      bus_read(7, d);
      check("sub_old_lo", d, 8'h01);

      run_op(200, 7, 3'd4, 1'b1);
      check("div_res", res_out, 16'd28);
      bus_read(0, d);
      check("a_locked_busy", d, 8'd200);
      run_op(200, 7, 3'd5, 1'b0);
      check("mod_res", res_out, 16'd4);

      run_op(5, 0, 3'd4, 1'b0);
      check("dz_res", res_out, 16'hFFFF);
      bus_read(8, d);
`ifdef ALU_DIVZERO_CNT_EN
      check("dz_cnt", d, 8'(m_dz));
`else
      check("addr8_zero", d, 0);
`endif
      run_op(5, 0, 3'd0, 1'b0);
      check("clear_res", res_out, 0);

      bus_write(2, 8'hFD);
      bus_read(2, d);
      check("op_low_bits", d, 8'h05);
      bus_write(3, 0);
      check("ex_bit0_zero", busy, 0);
      bus_read(3, d);
      check("ex_reads_0", d, 0);
      bus_read(9, d);
      check("unmapped_read", d, 0);
      bus_write(8, 8'h55);
      m_dz = 0;
      bus_read(8, d);
      check("addr8_cleared", d, 0);

      // Abort a divide part-way through with reset.
      bus_write(0, 200);
      bus_write(1, 3);
      bus_write(2, 4);
      bus_write(3, 1);
      repeat (4) @(posedge clk);
      #1;
      check("mid_div_busy", busy, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_res", res_out, 0);
      check("abort_done", done, 0);
      begin
         int seen = 0;
         for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (done) seen++;
         end
         check("abort_no_done", seen, 0);
      end
      m_res = '0; m_old = '0; m_err = 1'b0; m_dz = 0;
      run_op(10, 3, 3'd4, 1'b0);

      for (int i = 0; i < 40; i++) begin
         ra  = int'($urandom_range(0, 255));
         rb  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
         rop = 3'($urandom_range(0, 7));
         run_op(ra, rb, rop, 1'b0);
      end
      bus_read(8, d);
`ifdef ALU_DIVZERO_CNT_EN
      check("rand_dz_cnt", d, 8'(m_dz));
`else
      check("rand_addr8_zero", d, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
